// File: rtl/exception_ctrl.sv
// Multicycle exception sequencer: on a fault, writes the return address to EPC,
// fetches the handler vector byte from memory and loads it into PC.
module exception_ctrl #(
  parameter logic [31:0] VEC_OPCODE = 32'd253,
  parameter logic [31:0] VEC_OVF    = 32'd254,
  parameter logic [31:0] VEC_DIVZ   = 32'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_divz,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_rdata,
  output logic        exc_busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        epc_wr,
  output logic [31:0] epc_data,
  output logic        pc_wr,
  output logic [31:0] pc_data,
  output logic [1:0]  cause,
  output logic [7:0]  exc_count,
  output logic        exc_done
);

  typedef enum logic [2:0] {IDLE, SAVE, FETCH, LOAD, DONE} state_t;

  state_t      state;
  logic [31:0] ret_pc;
  logic [31:0] vec;
  logic        any_exc;
  logic [1:0]  sel_cause;
  logic [31:0] sel_vec;
  logic        unused_rdata;

  assign any_exc = exc_opcode | exc_ovf | exc_divz;

  // Priority: opcode > overflow > divide-by-zero
  always_comb begin
    sel_cause = 2'b11;
    sel_vec   = VEC_DIVZ;
    if (exc_opcode) begin
      sel_cause = 2'b01;
      sel_vec   = VEC_OPCODE;
    end else if (exc_ovf) begin
      sel_cause = 2'b10;
      sel_vec   = VEC_OVF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ret_pc    <= '0;
      vec       <= '0;
      cause     <= '0;
      exc_count <= '0;
      epc_wr    <= 1'b0;
      pc_wr     <= 1'b0;
      mem_req   <= 1'b0;
      exc_done  <= 1'b0;
    end else begin
      epc_wr   <= 1'b0;
      pc_wr    <= 1'b0;
      exc_done <= 1'b0;
      case (state)
        IDLE: if (any_exc) begin
          ret_pc    <= pc_in;
          vec       <= sel_vec;
          cause     <= sel_cause;
          exc_count <= exc_count + 8'd1;
          epc_wr    <= 1'b1;
          mem_req   <= 1'b1;
          state     <= SAVE;
        end
        SAVE:  state <= FETCH;
        FETCH: begin
          pc_wr <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          mem_req  <= 1'b0;
          exc_done <= 1'b1;
          state    <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read data arrives in LOAD, so pc_data passes it straight through
  assign exc_busy     = (state != IDLE);
  assign epc_data     = epc_wr  ? (ret_pc - 32'd4) : '0;
  assign mem_addr     = mem_req ? vec : '0;
  assign pc_data      = pc_wr   ? {24'b0, mem_rdata[7:0]} : '0;
  assign unused_rdata = ^mem_rdata[31:8];

endmodule

// File: tb/tb_exception_ctrl.sv
// Randomized scoreboard bench for exception_ctrl with a cycle-level reference model.
module tb_exception_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        exc_opcode = 1'b0, exc_ovf = 1'b0, exc_divz = 1'b0;
  logic [31:0] pc_in = '0, mem_rdata = '0;
  logic        exc_busy, mem_req, epc_wr, pc_wr, exc_done;
  logic [31:0] mem_addr, epc_data, pc_data;
  logic [1:0]  cause;
  logic [7:0]  exc_count;

  exception_ctrl dut (
    .clk(clk), .rst(rst), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_divz(exc_divz),
    .pc_in(pc_in), .mem_rdata(mem_rdata), .exc_busy(exc_busy), .mem_req(mem_req),
    .mem_addr(mem_addr), .epc_wr(epc_wr), .epc_data(epc_data), .pc_wr(pc_wr),
    .pc_data(pc_data), .cause(cause), .exc_count(exc_count), .exc_done(exc_done)
  );

  always #5 clk = ~clk;

  // Byte memory with one cycle read latency; upper bits are junk the DUT must drop
  logic [7:0] mem [0:255];
  always @(posedge clk) if (mem_req) mem_rdata <= {24'hA5C3E1, mem[mem_addr[7:0]]};

  typedef struct { logic [31:0] epc; logic [31:0] addr; logic [31:0] pcv; } exp_t;
  exp_t        q[$];
  int          total = 0, bad = 0;
  int          m_rem = 0;     // cycles of occupancy left in the reference model
  logic [1:0]  m_cause = 2'b00;
  logic [7:0]  m_count = 8'd0;
  int          acc_n = 0;

  function void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  function void model_reset();
    m_rem = 0; m_cause = 2'b00; m_count = 8'd0; q.delete();
  endfunction

  // Evaluated right after each rising edge with the inputs that edge sampled
  function void model_step();
    exp_t e;
    logic [1:0]  c;
    logic [31:0] v;
    if (m_rem == 0 && (exc_opcode || exc_ovf || exc_divz)) begin
      if (exc_opcode)   begin c = 2'b01; v = 32'd253; end
      else if (exc_ovf) begin c = 2'b10; v = 32'd254; end
      else              begin c = 2'b11; v = 32'd255; end
      e.epc  = pc_in - 32'd4;
      e.addr = v;
      e.pcv  = {24'b0, mem[v[7:0]]};
      q.push_back(e);
      m_cause = c;
      m_count = m_count + 8'd1;
      acc_n++;
      m_rem = 4;
    end else if (m_rem > 0) m_rem--;
  endfunction

  // Monitor: strobe timing from the model, data from the scoreboard queue
  always @(negedge clk) if (rst) begin
    chk("busy",  {31'b0, exc_busy}, {31'b0, m_rem != 0});
    chk("cause", {30'b0, cause}, {30'b0, m_cause});
    chk("count", {24'b0, exc_count}, {24'b0, m_count});
    chk("epc_wr",  {31'b0, epc_wr},   {31'b0, m_rem == 4});
    chk("mem_req", {31'b0, mem_req},  {31'b0, m_rem >= 2});
    chk("pc_wr",   {31'b0, pc_wr},    {31'b0, m_rem == 2});
    chk("done",    {31'b0, exc_done}, {31'b0, m_rem == 1});
    if (epc_wr && q.size() > 0) chk("epc_data", epc_data, q[0].epc);
    else if (!epc_wr)           chk("epc_data_idle", epc_data, 32'd0);
    if (mem_req && q.size() > 0) chk("mem_addr", mem_addr, q[0].addr);
    else if (!mem_req)           chk("mem_addr_idle", mem_addr, 32'd0);
    if (pc_wr && q.size() > 0) chk("pc_data", pc_data, q[0].pcv);
    else if (!pc_wr)           chk("pc_data_idle", pc_data, 32'd0);
    if (exc_done && q.size() > 0) void'(q.pop_front());
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    int a0, guard;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[254] = 8'h8C;
    #1 rst = 1'b0;
    #2;
    chk("rst_busy", {31'b0, exc_busy}, 32'd0);
    chk("rst_cause", {30'b0, cause}, 32'd0);
    chk("rst_count", {24'b0, exc_count}, 32'd0);
    chk("rst_strobes", {28'b0, epc_wr, pc_wr, mem_req, exc_done}, 32'd0);
    chk("rst_data", epc_data | pc_data | mem_addr, 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;

    // overflow with pc_in 0x40, vector byte 0x8C
    pc_in = 32'h40; exc_ovf = 1'b1; cyc(); exc_ovf = 1'b0; pc_in = $urandom;
    idle(6);
    chk("t_ovf_count", {24'b0, exc_count}, 32'd1);
    chk("t_ovf_cause", {30'b0, cause}, 32'd2);

    // opcode and divz together: opcode wins, one sequence
    exc_opcode = 1'b1; exc_divz = 1'b1; cyc(); exc_opcode = 1'b0; exc_divz = 1'b0;
    idle(6);
    chk("t_prio_count", {24'b0, exc_count}, 32'd2);
    chk("t_prio_cause", {30'b0, cause}, 32'd1);

    // divz re-pulsed during FETCH is ignored
    exc_ovf = 1'b1; cyc(); exc_ovf = 1'b0; cyc();
    exc_divz = 1'b1; cyc(); exc_divz = 1'b0;
    idle(6);
    chk("t_ign_count", {24'b0, exc_count}, 32'd3);
    chk("t_ign_cause", {30'b0, cause}, 32'd2);

    // pc_in = 0 wraps EPC value
    pc_in = 32'h0; exc_divz = 1'b1; cyc(); exc_divz = 1'b0;
    idle(6);
    chk("t_wrap_cause", {30'b0, cause}, 32'd3);

    // reset during FETCH aborts at once
    exc_ovf = 1'b1; cyc(); exc_ovf = 1'b0; cyc();
    #1 rst = 1'b0;
    #1;
    chk("t_abort_busy", {31'b0, exc_busy}, 32'd0);
    chk("t_abort_cause", {30'b0, cause}, 32'd0);
    chk("t_abort_count", {24'b0, exc_count}, 32'd0);
    chk("t_abort_wr", {30'b0, epc_wr, pc_wr}, 32'd0);
    model_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    pc_in = $urandom; exc_divz = 1'b1; cyc(); exc_divz = 1'b0;
    idle(6);
    chk("t_fresh_count", {24'b0, exc_count}, 32'd1);

    // 256 back-to-back overflows with the flag held high
    do_reset();
    a0 = acc_n; guard = 0;
    exc_ovf = 1'b1;
    while ((acc_n - a0) < 256 && guard < 2000) begin
      pc_in = $urandom; cyc(); guard++;
    end
    exc_ovf = 1'b0;
    chk("t_b2b_accepted", acc_n - a0, 32'd256);
    idle(6);
    chk("t_b2b_count", {24'b0, exc_count}, 32'd0);
    chk("t_b2b_cause", {30'b0, cause}, 32'd2);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      pc_in = $urandom;
      if (m_rem == 0 && $urandom_range(3) == 0)
        for (int k = 253; k < 256; k++) mem[k] = 8'($urandom);
      exc_opcode = ($urandom_range(5) == 0);
      exc_ovf    = ($urandom_range(5) == 0);
      exc_divz   = ($urandom_range(5) == 0);
      cyc();
    end
    exc_opcode = 1'b0; exc_ovf = 1'b0; exc_divz = 1'b0;
    idle(6);
    chk("t_rand_drain", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
